// File: rtl/bus_endpoint_fifo.sv
// bus_endpoint_fifo
//   Device-side endpoint for one bus port. A TX FIFO is filled by local logic
//   and presented to the bus through the pndng/pop/D_pop handshake. An RX FIFO
//   captures bus pushes addressed to this device (or to broadcast), and local
//   logic drains it.
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   wr_en, wr_data        : local write into TX FIFO; tx_full flags no room
//   pndng, D_pop, pop     : bus side of TX (head packet falls through to D_pop)
//   push, D_push          : bus delivery into RX (never back-pressured)
//   rd_en, rd_data        : local read from RX; rx_valid flags non-empty
//   tx_cnt, rx_cnt        : FIFO occupancies
//   err                   : sticky [0] TX overflow, [1] pop while empty, [2] RX drop
module bus_endpoint_fifo #(
    parameter int          pckg_sz   = 16,
    parameter int          DEPTH     = 8,
    parameter logic [7:0]  ID        = 8'd0,
    parameter logic [7:0]  broadcast = 8'hFF,
    parameter bit          FILTER    = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [pckg_sz-1:0]         wr_data,
    output logic                       tx_full,
    output logic                       pndng,
    output logic [pckg_sz-1:0]         D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    input  logic                       rd_en,
    output logic [pckg_sz-1:0]         rd_data,
    output logic                       rx_valid,
    output logic [$clog2(DEPTH):0]     tx_cnt,
    output logic [$clog2(DEPTH):0]     rx_cnt,
    output logic [2:0]                 err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [pckg_sz-1:0] tx_mem_q [DEPTH];
    logic [pckg_sz-1:0] rx_mem_q [DEPTH];
    logic [AW-1:0]      tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0]      rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0]      tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]         err_q, err_d;

    logic tx_do_pop, tx_do_wr, rx_acc, rx_do_rd, rx_do_wr;
    logic [7:0] dest;

    assign dest = D_push[pckg_sz-1 -: 8];

    always_comb begin
        // A pop frees a slot in the same cycle, so a write into a full FIFO
        // is still accepted when paired with a valid pop.
        tx_do_pop = pop && (tx_cnt_q != '0);
        tx_do_wr  = wr_en && ((tx_cnt_q != FULL) || tx_do_pop);
        rx_acc    = push && (!FILTER || (dest == ID) || (dest == broadcast));
        rx_do_rd  = rd_en && (rx_cnt_q != '0);
        rx_do_wr  = rx_acc && ((rx_cnt_q != FULL) || rx_do_rd);

        tx_wp_d  = tx_do_wr  ? tx_wp_q + AW'(1) : tx_wp_q;
        tx_rp_d  = tx_do_pop ? tx_rp_q + AW'(1) : tx_rp_q;
        rx_wp_d  = rx_do_wr  ? rx_wp_q + AW'(1) : rx_wp_q;
        rx_rp_d  = rx_do_rd  ? rx_rp_q + AW'(1) : rx_rp_q;
        tx_cnt_d = tx_cnt_q + CW'(tx_do_wr) - CW'(tx_do_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_do_wr) - CW'(rx_do_rd);

        err_d    = err_q;
        if (wr_en && !tx_do_wr)  err_d[0] = 1'b1;
        if (pop && !tx_do_pop)   err_d[1] = 1'b1;
        if (rx_acc && !rx_do_wr) err_d[2] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            err_q    <= '0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: outputs are gated by the occupancy counts.
    always_ff @(posedge clk) begin
        if (!reset && tx_do_wr) tx_mem_q[tx_wp_q] <= wr_data;
        if (!reset && rx_do_wr) rx_mem_q[rx_wp_q] <= D_push;
    end

    assign pndng    = (tx_cnt_q != '0);
    assign rx_valid = (rx_cnt_q != '0);
    assign tx_full  = (tx_cnt_q == FULL);
    assign D_pop    = pndng    ? tx_mem_q[tx_rp_q] : '0;
    assign rd_data  = rx_valid ? rx_mem_q[rx_rp_q] : '0;
    assign tx_cnt   = tx_cnt_q;
    assign rx_cnt   = rx_cnt_q;
    assign err      = err_q;
endmodule

// File: tb/tb_bus_endpoint_fifo.sv
// Self-checking bench for bus_endpoint_fifo (ID=3, DEPTH=8, 16-bit packets).
// A queue-based model tracks both FIFOs and the sticky error bits; a negedge
// process compares every output against it each cycle. Directed sequences
// add literal expectations, then a randomized run with a mid-stream reset.
module tb_bus_endpoint_fifo;
    localparam int DEPTH = 8;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset, wr_en, pop, push, rd_en;
    logic [W-1:0] wr_data, D_push, D_pop, rd_data;
    logic tx_full, pndng, rx_valid;
    logic [3:0] tx_cnt, rx_cnt;
    logic [2:0] err;

    int checks = 0;
    int errs   = 0;
    bit cmp_en = 1'b0;

    bus_endpoint_fifo #(.pckg_sz(W), .DEPTH(DEPTH), .ID(8'h03), .broadcast(8'hFF), .FILTER(1'b1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
        .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
        .rd_en(rd_en), .rd_data(rd_data), .rx_valid(rx_valid), .tx_cnt(tx_cnt),
        .rx_cnt(rx_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];
    logic [2:0]   m_err = 3'b000;
    bit m_pok, m_wok, m_acc, m_rok, m_pshok;

    always @(posedge clk) begin
        if (reset) begin
            txq.delete();
            rxq.delete();
            m_err = 3'b000;
        end else begin
            m_pok = pop && (txq.size() > 0);
            m_wok = wr_en && ((txq.size() < DEPTH) || m_pok);
            if (wr_en && !m_wok) m_err[0] = 1'b1;
            if (pop && !m_pok)   m_err[1] = 1'b1;
            m_acc   = push && (D_push[15:8] == 8'h03 || D_push[15:8] == 8'hFF);
            m_rok   = rd_en && (rxq.size() > 0);
            m_pshok = m_acc && ((rxq.size() < DEPTH) || m_rok);
            if (m_acc && !m_pshok) m_err[2] = 1'b1;
            if (m_pok)   void'(txq.pop_front());
            if (m_wok)   txq.push_back(wr_data);
            if (m_rok)   void'(rxq.pop_front());
            if (m_pshok) rxq.push_back(D_push);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pndng",    32'(pndng),    32'(txq.size() != 0));
            chk("D_pop",    32'(D_pop),    (txq.size() != 0) ? 32'(txq[0]) : 32'h0);
            chk("tx_full",  32'(tx_full),  32'(txq.size() == DEPTH));
            chk("tx_cnt",   32'(tx_cnt),   32'(txq.size()));
            chk("rx_valid", 32'(rx_valid), 32'(rxq.size() != 0));
            chk("rd_data",  32'(rd_data),  (rxq.size() != 0) ? 32'(rxq[0]) : 32'h0);
            chk("rx_cnt",   32'(rx_cnt),   32'(rxq.size()));
            chk("err",      32'(err),      32'(m_err));
        end
    end

    // Drives one cycle of inputs (called #1 after an edge), returns #1 after
    // the edge that sampled them with all inputs idle.
    task automatic cyc(input logic r, input logic w, input logic [W-1:0] wd, input logic p,
                       input logic ps, input logic [W-1:0] pd, input logic rd);
        reset = r; wr_en = w; wr_data = wd; pop = p; push = ps; D_push = pd; rd_en = rd;
        @(posedge clk); #1;
        reset = 0; wr_en = 0; wr_data = '0; pop = 0; push = 0; D_push = '0; rd_en = 0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_pndng"}, 32'(pndng), 0);
        chk({nm, "_D_pop"}, 32'(D_pop), 0);
        chk({nm, "_rxv"},   32'(rx_valid), 0);
        chk({nm, "_rd"},    32'(rd_data), 0);
        chk({nm, "_cnts"},  32'({tx_cnt, rx_cnt}), 0);
        chk({nm, "_full"},  32'(tx_full), 0);
        chk({nm, "_err"},   32'(err), 0);
    endtask

    initial begin
        reset = 1; wr_en = 0; wr_data = '0; pop = 0; push = 0; D_push = '0; rd_en = 0;
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cmp_en = 1'b1;
        chk_zero("reset");

        // basic TX write then pop
        cyc(0, 1, 16'h0312, 0, 0, 0, 0);
        chk("tx1_pndng", 32'(pndng), 1);
        chk("tx1_D_pop", 32'(D_pop), 32'h0312);
        chk("tx1_cnt",   32'(tx_cnt), 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("tx1p_pndng", 32'(pndng), 0);
        chk("tx1p_cnt",   32'(tx_cnt), 0);

        // RX filtering for ID=3
        cyc(0, 0, 0, 0, 1, 16'h03AB, 0);
        cyc(0, 0, 0, 0, 1, 16'h05CD, 0);
        cyc(0, 0, 0, 0, 1, 16'hFF01, 0);
        chk("rxf_cnt", 32'(rx_cnt), 2);
        chk("rxf_rd0", 32'(rd_data), 32'h03AB);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("rxf_rd1", 32'(rd_data), 32'hFF01);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("rxf_empty", 32'(rx_valid), 0);
        chk("rxf_err",   32'(err), 0);

        // TX overflow
        for (int i = 0; i <= DEPTH; i++) cyc(0, 1, 16'h1000 + 16'(i), 0, 0, 0, 0);
        chk("ovf_full", 32'(tx_full), 1);
        chk("ovf_cnt",  32'(tx_cnt), DEPTH);
        chk("ovf_err",  32'(err), 32'b001);
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_order", 32'(D_pop), 32'h1000 + i);
            cyc(0, 0, 0, 1, 0, 0, 0);
        end
        chk("ovf_drained", 32'(pndng), 0);

        // pop on empty, then write+pop on empty
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 16'hBEEF, 1, 0, 0, 0);
        chk("pe_err",  32'(err), 32'b010);
        chk("pe_cnt",  32'(tx_cnt), 1);
        chk("pe_dpop", 32'(D_pop), 32'hBEEF);

        // write+pop when full keeps the count
        for (int i = 1; i < DEPTH; i++) cyc(0, 1, 16'h2000 + 16'(i), 0, 0, 0, 0);
        cyc(0, 1, 16'h2AAA, 1, 0, 0, 0);
        chk("wpf_cnt", 32'(tx_cnt), DEPTH);
        chk("wpf_err", 32'(err), 32'b010);
        chk("wpf_head", 32'(D_pop), 32'h2001);

        // RX full: push+read no drop, push alone drops
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 1, 16'h0340 + 16'(i), 0);
        chk("rxfull_cnt", 32'(rx_cnt), DEPTH);
        cyc(0, 0, 0, 0, 1, 16'hFF77, 1);
        chk("rxpr_cnt", 32'(rx_cnt), DEPTH);
        chk("rxpr_err", 32'(err), 0);
        chk("rxpr_head", 32'(rd_data), 32'h0341);
        cyc(0, 0, 0, 0, 1, 16'h0399, 0);
        chk("rxdrop_err", 32'(err), 32'b100);
        cyc(0, 0, 0, 0, 1, 16'h0599, 0);
        chk("rxfilt_noerr", 32'(err), 32'b100);

        // randomized traffic with pointer wrap and a mid-stream reset
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'(i + 16'h0A00), 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            case ($urandom_range(0, 3))
                0: d = 8'h03;
                1: d = 8'hFF;
                2: d = 8'h05;
                default: d = 8'h03;
            endcase
            cyc((i == 450), ($urandom_range(0, 9) < 6), 16'($urandom),
                ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 6),
                {d, 8'($urandom)}, ($urandom_range(0, 9) < 4));
            if (i == 450) chk_zero("midrst");
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
